// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared constants, routing type and select-width helper for the
//            1-to-N stream demultiplexer.
// Contents : MAX_CH      - largest supported channel count
//            DROP_CNT_W  - width of the saturating drop counter
//            route_e     - how the current input word is routed
//            clog2()     - ceil(log2(n)), used to size the select input
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int MAX_CH     = 16;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    ROUTE_UNICAST = 2'd0,
    ROUTE_BCAST   = 2'd1,
    ROUTE_DROP    = 2'd2
  } route_e;

  // ceil(log2(n)) with a minimum of 1 so a 2-channel demux still gets a
  // one-bit select. The bounded loop keeps it usable at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_chan_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux_chan_buf
// Purpose  : One-entry output register for a single demux channel.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            load           - write load_data into the register this cycle
//            load_data      - payload to store
//            ready          - downstream ready for this channel
//            valid          - register holds a word
//            data           - stored payload (changes only on a load)
//            free_or_drain  - register can take a new word this cycle
// Revision : 1.0 - initial release
// ============================================================================
module demux_chan_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free_or_drain
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // A load wins over a release so a word arriving while the old one drains
  // keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid         = r_valid;
  assign data          = r_data;
  assign free_or_drain = ~r_valid | ready;

endmodule : demux_chan_buf
`default_nettype wire

// File: rtl/stream_demux_1_n.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1_n
// Purpose  : Valid/ready stream demultiplexer from one input to NUM_CH
//            registered output channels, with broadcast and a saturating
//            counter of words dropped for an out-of-range select.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            in_valid   - input word valid
//            in_ready   - input word accepted this cycle
//            in         - input payload
//            sel        - destination channel index
//            bcast      - send the word to every channel (sel ignored)
//            y          - channel payloads, channel c at [c*DATA_W +: DATA_W]
//            y_valid    - per-channel valid
//            y_ready    - per-channel ready
//            err        - one-cycle pulse after an out-of-range word is dropped
//            drop_cnt   - saturating count of dropped words
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1_n
  import demux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     bcast,
  output logic [NUM_CH*DATA_W-1:0] y,
  output logic [NUM_CH-1:0]        y_valid,
  input  logic [NUM_CH-1:0]        y_ready,
  output logic                     err,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);

  localparam logic [DROP_CNT_W-1:0] C_CNT_MAX = '1;

  route_e            w_route;
  logic              w_sel_in_range;
  logic              w_accept;
  logic              w_drop;
  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_load;

  logic                  r_err;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  assign w_sel_in_range = (int'(sel) < NUM_CH);

  always_comb begin
    w_route = ROUTE_DROP;
    if (bcast) begin
      w_route = ROUTE_BCAST;
    end else if (w_sel_in_range) begin
      w_route = ROUTE_UNICAST;
    end
  end

  // in_ready is a function of the routing and channel occupancy only, never
  // of in_valid; out-of-range words are always taken so they can be dropped.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (w_route)
        ROUTE_BCAST:   in_ready = &w_free;
        ROUTE_UNICAST: in_ready = w_free[sel];
        default:       in_ready = 1'b1;
      endcase
    end
  end

  assign w_accept = in_valid & in_ready;
  assign w_drop   = w_accept & (w_route == ROUTE_DROP);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      assign w_load[c] = w_accept &
                         ((w_route == ROUTE_BCAST) ||
                          ((w_route == ROUTE_UNICAST) && (sel == SEL_W'(c))));

      demux_chan_buf #(
        .DATA_W (DATA_W)
      ) u_buf (
        .clk           (clk),
        .rst           (rst),
        .load          (w_load[c]),
        .load_data     (in),
        .ready         (y_ready[c]),
        .valid         (y_valid[c]),
        .data          (y[c*DATA_W +: DATA_W]),
        .free_or_drain (w_free[c])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drop_cnt != C_CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign err      = r_err;
  assign drop_cnt = r_drop_cnt;

endmodule : stream_demux_1_n
`default_nettype wire

// File: tb/tb_stream_demux_1_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1_n
// Purpose  : Directed self-checking bench for stream_demux_1_n. An 8-channel
//            instance covers routing, back-pressure, broadcast and reset; a
//            6-channel instance covers out-of-range drops and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-channel instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data  = '0;
  logic [2:0]  sel      = '0;
  logic        bcast    = 1'b0;
  logic [63:0] y;
  logic [7:0]  y_valid;
  logic [7:0]  y_ready  = '0;
  logic        err;
  logic [7:0]  drop_cnt;

  // 6-channel instance
  logic        v6 = 1'b0;
  logic        rdy6;
  logic [7:0]  in6 = '0;
  logic [2:0]  sel6 = '0;
  logic        b6 = 1'b0;
  logic [47:0] y6;
  logic [5:0]  yv6;
  logic [5:0]  yr6 = 6'h3F;
  logic        err6;
  logic [7:0]  drop6;

  stream_demux_1_n #(.NUM_CH(8), .DATA_W(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in(in_data), .sel(sel), .bcast(bcast), .y(y), .y_valid(y_valid),
    .y_ready(y_ready), .err(err), .drop_cnt(drop_cnt)
  );

  stream_demux_1_n #(.NUM_CH(6), .DATA_W(8), .SEL_W(3)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rdy6),
    .in(in6), .sel(sel6), .bcast(b6), .y(y6), .y_valid(yv6),
    .y_ready(yr6), .err(err6), .drop_cnt(drop6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational in_ready settle after an input change.
  task automatic settle();
    #1;
  endtask

  function automatic logic [7:0] ch(input logic [63:0] bus, input int k);
    return bus[k*8 +: 8];
  endfunction

  initial begin
    // ---------------- reset state ----------------
    in_valid = 1'b1;
    sel      = 3'd0;
    in_data  = 8'hEE;
    y_ready  = 8'hFF;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y", y, 0);
    check("rst_err", err, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_in_ready6", rdy6, 0);
    in_valid = 1'b0;
    rst      = 1'b0;

    // ---------------- sequential unicast, full throughput ----------------
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      sel      = 3'(k);
      in_data  = 8'hA0 + 8'(k);
      settle();
      check($sformatf("uni_ready_%0d", k), in_ready, 1);
      tick();
      check($sformatf("uni_valid_%0d", k), y_valid, 64'(8'h01 << k));
      check($sformatf("uni_data_%0d", k), ch(y, k), 8'hA0 + 8'(k));
    end
    in_valid = 1'b0;
    tick();
    check("uni_drain", y_valid, 0);

    // ---------------- back-pressure on channel 3 ----------------
    y_ready  = 8'hF7;
    in_valid = 1'b1;
    sel      = 3'd3;
    in_data  = 8'h11;
    settle();
    check("bp_ready_first", in_ready, 1);
    tick();
    check("bp_valid_first", y_valid, 8'h08);
    check("bp_data_first", ch(y, 3), 8'h11);
    in_data = 8'h22;
    settle();
    check("bp_ready_blocked", in_ready, 0);
    tick();
    check("bp_hold_valid", y_valid, 8'h08);
    check("bp_hold_data", ch(y, 3), 8'h11);
    y_ready = 8'hFF;
    settle();
    check("bp_ready_drain", in_ready, 1);
    tick();
    check("bp_swap_valid", y_valid, 8'h08);
    check("bp_swap_data", ch(y, 3), 8'h22);
    in_valid = 1'b0;
    tick();
    check("bp_empty", y_valid, 0);

    // ---------------- broadcast blocked by a full channel ----------------
    y_ready  = 8'hBF;
    in_valid = 1'b1;
    sel      = 3'd6;
    in_data  = 8'h66;
    tick();
    check("bc_fill6", y_valid, 8'h40);
    bcast   = 1'b1;
    sel     = 3'd1;
    in_data = 8'h5A;
    settle();
    check("bc_ready_blocked", in_ready, 0);
    tick();
    check("bc_hold_valid", y_valid, 8'h40);
    check("bc_hold_data", ch(y, 6), 8'h66);
    y_ready = 8'hFF;
    settle();
    check("bc_ready_open", in_ready, 1);
    tick();
    check("bc_all_valid", y_valid, 8'hFF);
    check("bc_all_data", y, 64'h5A5A5A5A5A5A5A5A);
    in_valid = 1'b0;
    bcast    = 1'b0;
    tick();
    check("bc_drain", y_valid, 0);

    // ---------------- out-of-range drops on the 6-channel instance ----------------
    v6   = 1'b1;
    sel6 = 3'd7;
    in6  = 8'h77;
    for (int i = 0; i < 300; i++) begin
      in6 = 8'(i);
      settle();
      check($sformatf("oor_ready_%0d", i), rdy6, 1);
      tick();
      check($sformatf("oor_err_%0d", i), err6, 1);
      check($sformatf("oor_cnt_%0d", i), drop6, (i + 1 > 255) ? 255 : i + 1);
      check($sformatf("oor_yvalid_%0d", i), yv6, 0);
    end
    v6 = 1'b0;
    tick();
    check("oor_err_idle", err6, 0);
    check("oor_cnt_sat", drop6, 255);

    // ---------------- reset mid-stream ----------------
    y_ready  = 8'h00;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel     = 3'(k);
      in_data = 8'hB0 + 8'(k);
      tick();
    end
    check("mid_fill", y_valid, 8'h07);
    rst     = 1'b1;
    sel     = 3'd5;
    in_data = 8'hDD;
    settle();
    check("mid_rst_ready", in_ready, 0);
    tick();
    check("mid_rst_valid", y_valid, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_drop6", drop6, 0);
    check("mid_rst_err6", err6, 0);
    rst     = 1'b0;
    y_ready = 8'hFF;
    sel     = 3'd2;
    in_data = 8'hC3;
    settle();
    check("post_rst_ready", in_ready, 1);
    tick();
    check("post_rst_valid", y_valid, 8'h04);
    check("post_rst_data", ch(y, 2), 8'hC3);
    in_valid = 1'b0;
    tick();
    check("post_rst_drain", y_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_stream_demux_1_n
`default_nettype wire
